// File: rtl/tone_synth_voice.sv
// Single-voice square-wave tone synthesiser: one-pulse keys pick a note divider,
// stepped volume, timed hold then halving decay, registered stereo samples.
module tone_synth_voice #(
   parameter int NUM_KEYS  = 3,
   parameter int DIV_W     = 22,
   parameter int HOLD_CYC  = 25000000,
   parameter int DECAY_CYC = 2500000,
   parameter int VOL_RST   = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_KEYS-1:0]       key_pulse,
   input  logic [NUM_KEYS*DIV_W-1:0] key_div,
   input  logic                      vol_up,
   input  logic                      vol_dn,
   output logic [15:0]               audio_left,
   output logic [15:0]               audio_right,
   output logic [3:0]                vol_idx,
   output logic [3:0]                cur_key,
   output logic                      playing
);
   // state | meaning
   // IDLE  | silent, waiting for a key with a non-zero divider
   // PLAY  | full amplitude for HOLD_CYC cycles
   // DECAY | amplitude halves every DECAY_CYC cycles until it reaches zero
   typedef enum logic [1:0] {IDLE, PLAY, DECAY} state_t;

   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int DEC_W  = $clog2(DECAY_CYC + 1);

   state_t             state;
   logic [DIV_W-1:0]   div_lat;
   logic [DIV_W-1:0]   phase_cnt;
   logic               phase;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [DEC_W-1:0]   dec_cnt;
   logic [3:0]         shift;

   logic               key_hit;
   logic [3:0]         key_sel;
   logic [DIV_W-1:0]   div_sel;
   logic [15:0]        amp;
   logic [15:0]        sample;

   // Descending scan so the lowest-index pulsed key with a usable divider wins.
   always_comb begin
      key_hit = 1'b0;
      key_sel = '0;
      div_sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_pulse[i] && (key_div[i*DIV_W +: DIV_W] != '0)) begin
            key_hit = 1'b1;
            key_sel = 4'(i);
            div_sel = key_div[i*DIV_W +: DIV_W];
         end
      end
   end

   assign amp    = (16'd1 << vol_idx) >> shift;
   assign sample = phase ? (16'd0 - amp) : amp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vol_idx <= 4'(VOL_RST);
      end else if (vol_up && !vol_dn && (vol_idx != 4'd14)) begin
         vol_idx <= vol_idx + 4'd1;
      end else if (vol_dn && !vol_up && (vol_idx != 4'd0)) begin
         vol_idx <= vol_idx - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         playing     <= 1'b0;
         cur_key     <= '0;
         div_lat     <= '0;
         phase_cnt   <= '0;
         phase       <= 1'b0;
         hold_cnt    <= '0;
         dec_cnt     <= '0;
         shift       <= '0;
         audio_left  <= '0;
         audio_right <= '0;
      end else begin
         audio_left  <= (state == IDLE) ? 16'd0 : sample;
         audio_right <= (state == IDLE) ? 16'd0 : sample;

         if (state != IDLE) begin
            if (phase_cnt == div_lat - DIV_W'(1)) begin
               phase_cnt <= '0;
               phase     <= ~phase;
            end else begin
               phase_cnt <= phase_cnt + DIV_W'(1);
            end
         end

         if (key_hit) begin
            state     <= PLAY;
            playing   <= 1'b1;
            div_lat   <= div_sel;
            cur_key   <= key_sel;
            phase_cnt <= '0;
            phase     <= 1'b0;
            hold_cnt  <= '0;
            dec_cnt   <= '0;
            shift     <= '0;
         end else begin
            case (state)
               PLAY: begin
                  if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                     state   <= DECAY;
                     dec_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               DECAY: begin
                  if (dec_cnt == DEC_W'(DECAY_CYC - 1)) begin
                     dec_cnt <= '0;
                     // shift+1 > vol_idx means the next step would shift the amplitude to zero
                     if (shift >= vol_idx) begin
                        state   <= IDLE;
                        playing <= 1'b0;
                        cur_key <= '0;
                     end else begin
                        shift <= shift + 4'd1;
                     end
                  end else begin
                     dec_cnt <= dec_cnt + DEC_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tone_synth_voice.sv
// Scoreboard bench for tone_synth_voice: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_tone_synth_voice;
   localparam int NK   = 3;
   localparam int DW   = 8;
   localparam int HOLD = 20;
   localparam int DEC  = 5;
   localparam int VRST = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NK-1:0]     key_pulse;
   logic [NK*DW-1:0]  key_div;
   logic              vol_up;
   logic              vol_dn;
   logic [15:0]       audio_left;
   logic [15:0]       audio_right;
   logic [3:0]        vol_idx;
   logic [3:0]        cur_key;
   logic              playing;

   tone_synth_voice #(
      .NUM_KEYS(NK), .DIV_W(DW), .HOLD_CYC(HOLD), .DECAY_CYC(DEC), .VOL_RST(VRST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .key_div(key_div),
      .vol_up(vol_up), .vol_dn(vol_dn), .audio_left(audio_left), .audio_right(audio_right),
      .vol_idx(vol_idx), .cur_key(cur_key), .playing(playing)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] audio;
      logic        play;
      logic [3:0]  key;
      logic [3:0]  vol;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic compare(input exp_t e);
      tests++;
      if (audio_left !== e.audio || audio_right !== e.audio || playing !== e.play ||
          cur_key !== e.key || vol_idx !== e.vol) begin
         fails++;
         $display("FAIL %s: got audio_l=%h audio_r=%h playing=%b cur_key=%0d vol_idx=%0d; expected audio=%h playing=%b cur_key=%0d vol_idx=%0d",
                  e.name, audio_left, audio_right, playing, cur_key, vol_idx,
                  e.audio, e.play, e.key, e.vol);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            compare(e);
         end
      end
   end

   task automatic expect_out(input string n, input logic [15:0] a, input logic p,
                             input logic [3:0] k, input logic [3:0] v);
      exp_t e;
      e.name = n; e.audio = a; e.play = p; e.key = k; e.vol = v;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      key_pulse = '0;
      vol_up    = 1'b0;
      vol_dn    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Expected sample while the note is in its j-th cycle after the trigger edge.
   function automatic logic [15:0] exp_sample(input int j, input int div, input int vol);
      int s;
      logic [15:0] amp;
      s = (j < HOLD) ? 0 : (j - HOLD) / DEC;
      if (s > vol) return 16'h0000;
      amp = 16'd1 << vol;
      amp = amp >> s;
      return (((j / div) % 2) == 1) ? (16'h0000 - amp) : amp;
   endfunction

   function automatic logic exp_playing(input int j, input int vol);
      return (j < HOLD + DEC * (vol + 1));
   endfunction

   task automatic trigger(input string n, input logic [NK-1:0] bits, input logic [15:0] prev,
                          input logic [3:0] k, input logic [3:0] v);
      key_pulse = bits;
      tick();
      expect_out(n, prev, 1'b1, k, v);
   endtask

   task automatic run_note(input string n, input logic [3:0] k, input int div,
                           input int vol, input int cycles);
      logic p;
      for (int c = 1; c <= cycles; c++) begin
         tick();
         p = exp_playing(c, vol);
         expect_out(n, exp_sample(c - 1, div, vol), p, p ? k : 4'd0, 4'(vol));
      end
   endtask

   initial begin
      exp_t e;
      key_pulse = '0;
      key_div   = '0;
      vol_up    = 1'b0;
      vol_dn    = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 1000; i++) begin
         tick();
         expect_out("idle_reset", 16'h0000, 1'b0, 4'd0, 4'd10);
      end

      // basic square wave on key 0, div 4
      key_div = {8'd3, 8'd6, 8'd4};
      trigger("sq_trig", 3'b001, 16'h0000, 4'd0, 4'd10);
      run_note("sq_wave", 4'd0, 4, 10, 16);

      // envelope at vol 2
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         vol_dn = 1'b1;
         tick();
         expect_out("env_voldn", 16'h0000, 1'b0, 4'd0, 4'(10 - i));
      end
      trigger("env_trig", 3'b001, 16'h0000, 4'd0, 4'd2);
      run_note("env_shape", 4'd0, 4, 2, 40);

      // priority, then retrigger mid-decay with key 2
      do_reset();
      trigger("prio_trig", 3'b110, 16'h0000, 4'd1, 4'd10);
      run_note("prio_key1", 4'd1, 6, 10, 26);
      trigger("retrig", 3'b100, exp_sample(26, 6, 10), 4'd2, 4'd10);
      run_note("retrig_key2", 4'd2, 3, 10, 12);

      // volume saturation
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         vol_up = 1'b1;
         tick();
         expect_out("vol_up_sat", 16'h0000, 1'b0, 4'd0, 4'((10 + i > 14) ? 14 : 10 + i));
      end
      vol_up = 1'b1;
      vol_dn = 1'b1;
      tick();
      expect_out("vol_both", 16'h0000, 1'b0, 4'd0, 4'd14);
      for (int i = 1; i <= 20; i++) begin
         vol_dn = 1'b1;
         tick();
         expect_out("vol_dn_sat", 16'h0000, 1'b0, 4'd0, 4'((14 - i < 0) ? 0 : 14 - i));
      end
      for (int i = 1; i <= 14; i++) begin
         vol_up = 1'b1;
         tick();
         expect_out("vol_up_back", 16'h0000, 1'b0, 4'd0, 4'(i));
      end
      trigger("vmax_trig", 3'b001, 16'h0000, 4'd0, 4'd14);
      run_note("vmax_wave", 4'd0, 4, 14, 10);

      // async reset mid-note, then zero-divider key
      do_reset();
      vol_up = 1'b1;
      tick();
      expect_out("ar_volup", 16'h0000, 1'b0, 4'd0, 4'd11);
      trigger("ar_trig", 3'b001, 16'h0000, 4'd0, 4'd11);
      run_note("ar_wave", 4'd0, 4, 11, 6);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      e.name = "async_reset"; e.audio = 16'h0000; e.play = 1'b0; e.key = 4'd0; e.vol = 4'd10;
      compare(e);
      #1;
      rst_n = 1'b1;
      key_div = {8'd3, 8'd6, 8'd0};
      trigger("zero_div", 3'b001, 16'h0000, 4'd0, 4'd10);
      q.pop_back();
      expect_out("zero_div", 16'h0000, 1'b0, 4'd0, 4'd10);
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_out("zero_div_idle", 16'h0000, 1'b0, 4'd0, 4'd10);
      end

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
